// File: rtl/sdram_blockdev_responder_if.sv
// Bundle of the block-device handshake (initiator side) and the SDRAM
// req/ack port used by sdram_blockdev_responder.
// slave  : the responder's view (drives io_ack, buffer strobes, mem requests).
// master : the environment's view (initiator plus SDRAM arbiter port).
interface sdram_blockdev_responder_if;
    logic [16:0] image_blocks;
    logic [31:0] io_lba;
    logic        io_rd;
    logic        io_wr;
    logic        io_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic        mem_req;
    logic        mem_we;
    logic [24:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_ds;
    logic        mem_ack;
    logic [15:0] mem_dout;
    logic        oob;

    modport slave (
        input  image_blocks, io_lba, io_rd, io_wr, sd_buff_din, mem_ack, mem_dout,
        output io_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_req, mem_we, mem_addr, mem_din, mem_ds, oob
    );

    modport master (
        output image_blocks, io_lba, io_rd, io_wr, sd_buff_din, mem_ack, mem_dout,
        input  io_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_req, mem_we, mem_addr, mem_din, mem_ds, oob
    );
endinterface

// File: rtl/sdram_blockdev_responder.sv
// Block-device responder serving 512-byte blocks from a disk image held
// in SDRAM. Each block is moved as 256 big-endian 16-bit words; requests
// beyond the image size are answered with fill data (reads) or swallowed
// (writes) without touching SDRAM.
module sdram_blockdev_responder #(
    parameter logic [24:0] BASE_ADDR     = 25'h0200000,
    parameter int unsigned ZERO_FILL_OOB = 1
) (
    input  logic                         clk_sys,
    input  logic                         n_reset,
    sdram_blockdev_responder_if.slave    bus
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_MEM = 4'd1;
    localparam logic [3:0] S_RD_HI  = 4'd2;
    localparam logic [3:0] S_RD_LO  = 4'd3;
    localparam logic [3:0] S_WR_ADR = 4'd4;
    localparam logic [3:0] S_WR_HI  = 4'd5;
    localparam logic [3:0] S_WR_LO  = 4'd6;
    localparam logic [3:0] S_WR_MEM = 4'd7;
    localparam logic [3:0] S_DONE   = 4'd8;

    localparam logic [15:0] OOB_FILL = (ZERO_FILL_OOB != 0) ? 16'h0000 : 16'hFFFF;

    logic [3:0]  state_q, state_d;
    logic [16:0] lba_q, lba_d;
    logic [7:0]  w_q, w_d;
    logic [15:0] word_q, word_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  lo_q, lo_d;
    logic        oob_xfer_q, oob_xfer_d;
    logic        oob_pulse_q, oob_pulse_d;

    logic        req_oob;
    logic        last_word;
    logic [24:0] word_addr;
    logic        in_mem_state;

    // Range check is done on the full 32-bit lba so high bits cannot alias
    // into the image.
    assign req_oob      = (bus.io_lba >= {15'b0, bus.image_blocks});
    assign last_word    = (w_q == 8'hFF);
    assign word_addr    = BASE_ADDR + {lba_q, w_q};
    assign in_mem_state = (state_q == S_RD_MEM) || (state_q == S_WR_MEM);

    // Next-state and datapath decisions for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        lba_d       = lba_q;
        w_d         = w_q;
        word_d      = word_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        oob_xfer_d  = oob_xfer_q;
        oob_pulse_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.io_rd || bus.io_wr) begin
                    lba_d       = bus.io_lba[16:0];
                    w_d         = '0;
                    oob_xfer_d  = req_oob;
                    oob_pulse_d = req_oob;
                    state_d     = bus.io_rd ? S_RD_MEM : S_WR_ADR;
                end
            end
            S_RD_MEM: begin
                if (oob_xfer_q) begin
                    word_d  = OOB_FILL;
                    state_d = S_RD_HI;
                end else if (bus.mem_ack) begin
                    word_d  = bus.mem_dout;
                    state_d = S_RD_HI;
                end
            end
            S_RD_HI: begin
                state_d = S_RD_LO;
            end
            S_RD_LO: begin
                if (last_word) begin
                    state_d = S_DONE;
                end else begin
                    w_d     = w_q + 8'd1;
                    state_d = S_RD_MEM;
                end
            end
            S_WR_ADR: begin
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                hi_d    = bus.sd_buff_din;
                state_d = S_WR_LO;
            end
            S_WR_LO: begin
                lo_d    = bus.sd_buff_din;
                state_d = S_WR_MEM;
            end
            S_WR_MEM: begin
                if (oob_xfer_q || bus.mem_ack) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else begin
                        w_d     = w_q + 8'd1;
                        state_d = S_WR_ADR;
                    end
                end
            end
            S_DONE: begin
                if (!bus.io_rd && !bus.io_wr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk_sys) begin
        if (!n_reset) begin
            state_q     <= S_IDLE;
            lba_q       <= '0;
            w_q         <= '0;
            word_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            oob_xfer_q  <= 1'b0;
            oob_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lba_q       <= lba_d;
            w_q         <= w_d;
            word_q      <= word_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            oob_xfer_q  <= oob_xfer_d;
            oob_pulse_q <= oob_pulse_d;
        end
    end

    // Outputs decoded from state; everything is zero outside its active state.
    always_comb begin
        bus.io_ack       = (state_q != S_IDLE) && (state_q != S_DONE);
        bus.oob          = oob_pulse_q;
        bus.mem_req      = in_mem_state && !oob_xfer_q;
        bus.mem_we       = bus.mem_req && (state_q == S_WR_MEM);
        bus.mem_addr     = bus.mem_req ? word_addr : '0;
        bus.mem_din      = bus.mem_we ? {hi_q, lo_q} : '0;
        bus.mem_ds       = bus.mem_req ? 2'b11 : 2'b00;
        bus.sd_buff_wr   = (state_q == S_RD_HI) || (state_q == S_RD_LO);
        bus.sd_buff_addr = '0;
        bus.sd_buff_dout = '0;
        case (state_q)
            S_RD_HI: begin
                bus.sd_buff_addr = {w_q, 1'b0};
                bus.sd_buff_dout = word_q[15:8];
            end
            S_RD_LO: begin
                bus.sd_buff_addr = {w_q, 1'b1};
                bus.sd_buff_dout = word_q[7:0];
            end
            S_WR_ADR: begin
                bus.sd_buff_addr = {w_q, 1'b0};
            end
            S_WR_HI, S_WR_LO: begin
                bus.sd_buff_addr = {w_q, 1'b1};
            end
            default: begin
                bus.sd_buff_addr = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_blockdev_responder.sv
// Bench for sdram_blockdev_responder: SDRAM and initiator-buffer models,
// an expectation scoreboard built from block/word arithmetic, and a
// negedge compare process.
`timescale 1ns/1ps
module tb_sdram_blockdev_responder;
    localparam logic [24:0] BASE = 25'h0200000;

    logic clk_sys = 1'b0;
    logic n_reset = 1'b0;
    always #5 clk_sys = ~clk_sys;

    sdram_blockdev_responder_if bus();

    sdram_blockdev_responder #(.BASE_ADDR(BASE), .ZERO_FILL_OOB(1)) dut (
        .clk_sys (clk_sys),
        .n_reset (n_reset),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- SDRAM model ----------------
    logic [15:0] sdram [int];
    int lat = 0;
    int wait_cnt = 0;

    function automatic logic [15:0] mem_val(input int a);
        if (sdram.exists(a)) return sdram[a];
        return a[15:0] ^ 16'hC3A5;
    endfunction

    always @(posedge clk_sys) begin
        if (!n_reset) begin
            bus.mem_ack <= 1'b0;
            wait_cnt    <= 0;
        end else begin
            bus.mem_ack <= 1'b0;
            if (bus.mem_req && !bus.mem_ack) begin
                if (wait_cnt >= lat) begin
                    bus.mem_ack <= 1'b1;
                    wait_cnt    <= 0;
                    if (bus.mem_we) sdram[int'(bus.mem_addr)] = bus.mem_din;
                    else            bus.mem_dout <= mem_val(int'(bus.mem_addr));
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
        end
    end

    // ---------------- initiator buffer model (1-cycle read latency) ----------------
    logic [7:0] ibuf [512];
    always @(posedge clk_sys) bus.sd_buff_din <= ibuf[bus.sd_buff_addr];

    // ---------------- scoreboard ----------------
    logic [16:0] exp_b [$];   // {buffer addr, byte}
    logic [41:0] exp_m [$];   // {we, word addr, write data}
    int n_bw = 0, n_mr = 0, n_oob = 0, n_ack = 0;
    logic        prev_req = 1'b0, prev_ack = 1'b0;
    logic [41:0] held;
    logic [41:0] cur;
    logic [7:0]  seen [512];

    always @(negedge clk_sys) begin
        if (n_reset) begin
            if (bus.sd_buff_wr) begin
                n_bw++;
                seen[bus.sd_buff_addr] = bus.sd_buff_dout;
                if (exp_b.size() == 0) check("buff_wr_unexpected", bus.sd_buff_wr, 1'b0);
                else check("buff_wr", {bus.sd_buff_addr, bus.sd_buff_dout}, exp_b.pop_front());
            end
            if (bus.mem_req) begin
                cur = {bus.mem_we, bus.mem_addr, bus.mem_din};
                check("req_inside_ack", bus.io_ack, 1'b1);
                check("mem_ds", bus.mem_ds, 2'b11);
                if (!prev_req) begin
                    n_mr++;
                    held = cur;
                    if (exp_m.size() == 0) check("mem_req_unexpected", bus.mem_req, 1'b0);
                    else begin
                        logic [41:0] e;
                        e = exp_m.pop_front();
                        if (e[41]) check("mem_wr_req", cur, e);
                        else       check("mem_rd_req", cur[41:16], e[41:16]);
                    end
                end else begin
                    check("mem_req_stable", cur, held);
                end
            end
            if (bus.oob) n_oob++;
            if (bus.io_ack && !prev_ack) n_ack++;
        end
        prev_req = n_reset && bus.mem_req;
        prev_ack = n_reset && bus.io_ack;
    end

    // Expected traffic for one block: word k lives at BASE + lba*256 + k.
    task automatic prime(input bit is_rd, input logic [31:0] lba, input bit ob);
        logic [24:0] a;
        logic [15:0] v;
        for (int k = 0; k < 256; k++) begin
            a = 25'(32'(BASE) + 32'(lba[16:0]) * 32'd256 + 32'(k));
            if (is_rd) begin
                v = ob ? 16'h0000 : mem_val(int'(a));
                if (!ob) exp_m.push_back({1'b0, a, 16'h0000});
                exp_b.push_back({9'(2 * k), v[15:8]});
                exp_b.push_back({9'(2 * k + 1), v[7:0]});
            end else if (!ob) begin
                exp_m.push_back({1'b1, a, ibuf[2 * k], ibuf[2 * k + 1]});
            end
        end
    endtask

    task automatic await_end(input string name);
        int t;
        t = 0;
        while (!bus.io_ack && t < 50) begin @(negedge clk_sys); t++; end
        while (bus.io_ack && t < 6000) begin @(negedge clk_sys); t++; end
        check({name, "_timeout"}, (t < 6000), 1'b1);
    endtask

    // One full transfer, starting and ending on a negedge.
    task automatic xfer(input bit rd, input bit wr, input logic [31:0] lba,
                        input logic [16:0] blocks, input int hold);
        int b0, m0, o0, a0;
        bit is_rd, ob;
        b0 = n_bw; m0 = n_mr; o0 = n_oob; a0 = n_ack;
        is_rd = rd;
        ob = (lba >= {15'b0, blocks});
        bus.image_blocks = blocks;
        bus.io_lba = lba;
        prime(is_rd, lba, ob);
        bus.io_rd = rd;
        bus.io_wr = wr;
        @(posedge clk_sys); @(negedge clk_sys);
        check("ack_rise", bus.io_ack, 1'b1);
        check("oob_pulse", bus.oob, ob);
        @(negedge clk_sys);
        check("oob_one_cycle", bus.oob, 1'b0);
        bus.io_lba = $urandom;
        await_end("xfer");
        repeat (hold) @(negedge clk_sys);
        check("buff_wr_count", n_bw - b0, is_rd ? 512 : 0);
        check("mem_req_count", n_mr - m0, ob ? 0 : 256);
        check("oob_count", n_oob - o0, ob);
        check("single_service", n_ack - a0, 1);
        check("exp_left", exp_b.size() + exp_m.size(), 0);
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        repeat (2) @(negedge clk_sys);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, m0, t;
        bus.io_rd = 1'b0;
        bus.io_wr = 1'b0;
        bus.io_lba = '0;
        bus.image_blocks = '0;
        for (int i = 0; i < 512; i++) begin ibuf[i] = 8'h00; seen[i] = 8'h00; end
        sdram[32'h200300] = 16'hA55A;
        sdram[32'h2003FF] = 16'h1234;
        n_reset = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("reset_outputs",
              {bus.io_ack, bus.mem_req, bus.sd_buff_wr, bus.oob, bus.mem_we,
               bus.sd_buff_addr, bus.sd_buff_dout, bus.mem_addr, bus.mem_ds}, '0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        check("idle_no_ack", bus.io_ack, 1'b0);

        // Read in range, literal bytes pin the model.
        xfer(1'b1, 1'b0, 32'd3, 17'd10, 0);
        check("byte0", seen[0], 8'hA5);
        check("byte1", seen[1], 8'h5A);
        check("byte510", seen[510], 8'h12);
        check("byte511", seen[511], 8'h34);

        // Write block 0 with buffer byte i = i.
        for (int i = 0; i < 512; i++) ibuf[i] = 8'(i);
        xfer(1'b0, 1'b1, 32'd0, 17'd10, 0);
        check("wr_word0", mem_val(32'h200000), 16'h0001);
        check("wr_word127", mem_val(32'h20007F), 16'hFEFF);

        // Out of range read and write.
        xfer(1'b1, 1'b0, 32'd10, 17'd10, 0);
        check("oob_fill", seen[300], 8'h00);
        xfer(1'b0, 1'b1, 32'd0, 17'd0, 0);
        xfer(1'b1, 1'b0, 32'h80000002, 17'd10, 0);

        // Read/write contention, then long mem latency on both paths.
        xfer(1'b1, 1'b1, 32'd5, 17'd10, 0);
        lat = 5;
        xfer(1'b1, 1'b0, 32'd0, 17'd10, 0);
        for (int i = 0; i < 512; i++) ibuf[i] = 8'($urandom);
        xfer(1'b0, 1'b1, 32'd7, 17'd10, 0);
        lat = 0;

        // Held request serviced once, then a fresh one at block 4.
        xfer(1'b1, 1'b0, 32'd1, 17'd10, 100);
        xfer(1'b1, 1'b0, 32'd4, 17'd10, 0);

        // Reset mid-read after ~100 bytes.
        bus.image_blocks = 17'd10;
        bus.io_lba = 32'd6;
        prime(1'b1, 32'd6, 1'b0);
        b0 = n_bw;
        bus.io_rd = 1'b1;
        t = 0;
        while ((n_bw - b0) < 100 && t < 2000) begin @(negedge clk_sys); t++; end
        check("rst_wait_timeout", (t < 2000), 1'b1);
        n_reset = 1'b0;
        @(posedge clk_sys); @(negedge clk_sys);
        check("rst_mid_outputs", {bus.io_ack, bus.mem_req, bus.sd_buff_wr}, 3'b000);
        exp_b.delete();
        exp_m.delete();
        prime(1'b1, 32'd6, 1'b0);
        b0 = n_bw; m0 = n_mr;
        n_reset = 1'b1;
        await_end("rst_restart");
        check("rst_restart_bytes", n_bw - b0, 512);
        check("rst_restart_reqs", n_mr - m0, 256);
        check("rst_exp_left", exp_b.size() + exp_m.size(), 0);
        bus.io_rd = 1'b0;
        repeat (2) @(negedge clk_sys);

        // Randomized transfers.
        for (int n = 0; n < 8; n++) begin
            logic [16:0] blk;
            logic [31:0] l;
            bit r;
            blk = 17'($urandom_range(0, 12));
            l   = 32'($urandom_range(0, 14));
            r   = 1'($urandom_range(0, 1));
            lat = int'($urandom_range(0, 3));
            for (int i = 0; i < 512; i++) ibuf[i] = 8'($urandom);
            xfer(r, !r, l, blk, int'($urandom_range(0, 5)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
